// File: rtl/guvm_wb_pkg.sv
// ----------------------------------------------------------------------------
// guvm_wb_pkg
// Shared definitions for the GUVM Wishbone responder:
//   NOP_INST / NOP_LINE : filler returned on instruction lanes with no payload
//   wb_state_e          : responder bus-cycle FSM states
//   in_window()         : overflow-safe [base, base+size) address test
// ----------------------------------------------------------------------------
package guvm_wb_pkg;

  localparam logic [31:0]  NOP_INST = 32'hF0081003;
  localparam logic [127:0] NOP_LINE = {4{NOP_INST}};

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    GAP
  } wb_state_e;

  // Compare in 33 bits so a window ending at 4 GiB does not wrap to zero.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, adr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/guvm_inj_fifo.sv
// ----------------------------------------------------------------------------
// guvm_inj_fifo
// Synchronous single-clock FIFO holding instructions injected by the driver.
//   i_clk, i_rst       : clock, synchronous active-high reset (flushes FIFO)
//   i_push, i_data     : write request / data (ignored while full)
//   i_pop              : read request (ignored while empty)
//   o_head             : entry at the read pointer
//   o_count            : occupancy, 0..DEPTH
//   o_full, o_empty    : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module guvm_inj_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately not reset; only the pointers and
  // count define validity, and a reset would block RAM inference.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/guvm_wb_responder.sv
// ----------------------------------------------------------------------------
// guvm_wb_responder
// Wishbone classic-cycle slave for the GUVM core benches (128-bit data).
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_wb_cyc/stb/we/adr/sel/dat : master request (byte address, byte enables)
//   o_wb_dat                    : registered read data, held between responses
//   o_wb_ack / o_wb_err         : one-cycle normal / error termination
//   i_inj_valid, i_inj_data     : driver pushes one instruction per cycle
//   o_inj_ready, o_inj_count    : injection FIFO not-full flag / occupancy
// Reads in the instruction window return the FIFO head on lane adr[3:2] and
// NOP on the other lanes; RAM-window accesses hit a line RAM; anything else,
// including instruction-window writes, terminates with err.
// ----------------------------------------------------------------------------
module guvm_wb_responder
  import guvm_wb_pkg::*;
#(
  parameter int unsigned MEM_LINES   = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] INST_BASE   = 32'h0000_0000,
  parameter logic [31:0] INST_BYTES  = 32'h0000_0100,
  parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
  parameter int unsigned INJ_DEPTH   = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wb_cyc,
  input  logic                             i_wb_stb,
  input  logic                             i_wb_we,
  input  logic [31:0]                      i_wb_adr,
  input  logic [15:0]                      i_wb_sel,
  input  logic [127:0]                     i_wb_dat,
  output logic [127:0]                     o_wb_dat,
  output logic                             o_wb_ack,
  output logic                             o_wb_err,
  input  logic                             i_inj_valid,
  input  logic [31:0]                      i_inj_data,
  output logic                             o_inj_ready,
  output logic [$clog2(INJ_DEPTH+1)-1:0]   o_inj_count
);

  localparam int unsigned LINE_W    = $clog2(MEM_LINES);
  localparam logic [31:0] RAM_BYTES = 32'(16 * MEM_LINES);

  wb_state_e      r_state;
  wb_state_e      w_next;
  logic [3:0]     r_wait_cnt;
  logic [31:0]    r_adr;
  logic           r_we;
  logic [15:0]    r_sel;
  logic [127:0]   r_wdat;
  logic [127:0]   r_dat;
  logic           r_ack;
  logic           r_err;
  logic           r_pop_pend;
  logic           r_ram_wr;
  logic [127:0]   r_mem [MEM_LINES];

  logic           w_req;
  logic [31:0]    w_adr;
  logic           w_we;
  logic           w_hit_inst;
  logic           w_hit_ram;
  logic           w_enter_resp;
  logic [127:0]   w_inst_line;
  logic [LINE_W-1:0] w_line;

  logic [31:0]    w_fifo_head;
  logic           w_fifo_full;
  logic           w_fifo_empty;

  assign w_req = i_wb_cyc & i_wb_stb;

  // With zero wait states the request is latched on the same edge that enters
  // RESP, so decode looks through to the bus while still in IDLE.
  assign w_adr  = (r_state == IDLE) ? i_wb_adr : r_adr;
  assign w_we   = (r_state == IDLE) ? i_wb_we  : r_we;
  assign w_line = w_adr[LINE_W+3:4];

  // ---------------------------------------------------------------- FSM: state
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // ----------------------------------------------------------- FSM: next state
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!w_req)                 w_next = IDLE;
        else if (r_wait_cnt == 4'd1) w_next = RESP;
      end
      RESP:    w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------- FSM: outputs
  always_comb begin
    w_enter_resp = (w_next == RESP);
    w_hit_inst   = in_window(w_adr, INST_BASE, INST_BYTES) & ~w_we;
    w_hit_ram    = in_window(w_adr, RAM_BASE, RAM_BYTES);
    w_inst_line  = NOP_LINE;
    if (!w_fifo_empty) w_inst_line[{w_adr[3:2], 5'd0} +: 32] = w_fifo_head;
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_adr      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_pop_pend <= 1'b0;
      r_ram_wr   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_adr      <= i_wb_adr;
        r_we       <= i_wb_we;
        r_sel      <= i_wb_sel;
        r_wdat     <= i_wb_dat;
        r_wait_cnt <= 4'(WAIT_STATES);
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      // These flags are set on the edge entering RESP and therefore live for
      // exactly the RESP cycle; pop and write take effect at its closing edge.
      r_ack      <= w_enter_resp &  (w_hit_inst | w_hit_ram);
      r_err      <= w_enter_resp & ~(w_hit_inst | w_hit_ram);
      // Pop only if a real head was returned: a push landing later in the
      // response must not be consumed behind a NOP.
      r_pop_pend <= w_enter_resp & w_hit_inst & ~w_fifo_empty;
      r_ram_wr   <= w_enter_resp & w_hit_ram & w_we;

      if (w_enter_resp && !w_we) begin
        if (w_hit_inst)     r_dat <= w_inst_line;
        else if (w_hit_ram) r_dat <= r_mem[w_line];
      end
    end
  end

  // RAM write at the closing edge of RESP; a reset on that edge cancels it.
  always_ff @(posedge i_clk) begin
    if (r_ram_wr && !i_rst) begin
      for (int k = 0; k < 16; k++) begin
        if (r_sel[k]) r_mem[r_adr[LINE_W+3:4]][8*k +: 8] <= r_wdat[8*k +: 8];
      end
    end
  end

  guvm_inj_fifo #(
    .WIDTH (32),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_inj_valid),
    .i_data  (i_inj_data),
    .i_pop   (r_pop_pend),
    .o_head  (w_fifo_head),
    .o_count (o_inj_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_wb_dat    = r_dat;
  assign o_wb_ack    = r_ack;
  assign o_wb_err    = r_err;
  assign o_inj_ready = ~w_fifo_full;

endmodule

// File: tb/tb_guvm_wb_responder.sv
// ----------------------------------------------------------------------------
// tb_guvm_wb_responder
// Scoreboard bench: the driver predicts each response from a behavioural model
// (instruction queue + line array) and queues it; an independent monitor pops
// and compares whenever ack or err appears.
// ----------------------------------------------------------------------------
module tb_guvm_wb_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 8;
  localparam int LINES = 256;
  localparam logic [31:0] NOP = 32'hF0081003;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_cyc, wb_stb, wb_we;
  logic [31:0]  wb_adr;
  logic [15:0]  wb_sel;
  logic [127:0] wb_wdat;
  logic [127:0] o_wb_dat;
  logic         o_wb_ack, o_wb_err;
  logic         inj_valid;
  logic [31:0]  inj_data;
  logic         o_inj_ready;
  logic [3:0]   o_inj_count;

  guvm_wb_responder #(
    .MEM_LINES   (LINES),
    .WAIT_STATES (WS),
    .INST_BASE   (32'h0000_0000),
    .INST_BYTES  (32'h0000_0100),
    .RAM_BASE    (32'h0000_1000),
    .INJ_DEPTH   (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_cyc    (wb_cyc),
    .i_wb_stb    (wb_stb),
    .i_wb_we     (wb_we),
    .i_wb_adr    (wb_adr),
    .i_wb_sel    (wb_sel),
    .i_wb_dat    (wb_wdat),
    .o_wb_dat    (o_wb_dat),
    .o_wb_ack    (o_wb_ack),
    .o_wb_err    (o_wb_err),
    .i_inj_valid (inj_valid),
    .i_inj_data  (inj_data),
    .o_inj_ready (o_inj_ready),
    .o_inj_count (o_inj_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    bit           is_err;
    bit           chk;
    logic [127:0] dat;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  inst_q[$];
  logic [127:0] ram_m[LINES];
  bit           ram_known[LINES];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a, input longint base, input longint size);
    return (longint'(a) >= base) && (longint'(a) < base + size);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete bus transaction; optionally pushes pdata on the ack cycle.
  task automatic bus(input bit we, input logic [31:0] adr, input logic [15:0] sel,
                     input logic [127:0] dat, input bit push_at_ack = 1'b0,
                     input logic [31:0] pdata = 32'h0);
    exp_t e;
    bit   inst, ram, got, ready_pre;
    int   line, lane;
    inst = !we && in_win(adr, 64'h0, 64'h100);
    ram  = in_win(adr, 64'h1000, 64'(16 * LINES));
    line = int'(adr >> 4) % LINES;
    lane = int'(adr >> 2) % 4;
    e.is_err = !(inst || ram);
    e.chk    = 1'b0;
    e.dat    = '0;
    if (inst) begin
      for (int k = 0; k < 4; k++) e.dat[32*k +: 32] = NOP;
      if (inst_q.size() > 0) e.dat[32*lane +: 32] = inst_q[0];
      e.chk = 1'b1;
    end else if (ram && !we && ram_known[line]) begin
      e.dat = ram_m[line];
      e.chk = 1'b1;
    end
    @(negedge clk);
    e.due   = cyc + 1 + WS;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = we;
    wb_adr  = adr;
    wb_sel  = sel;
    wb_wdat = dat;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = o_wb_ack | o_wb_err;
    end
    if (!got) check("bus_timeout", 128'd0, 128'd1);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    if (push_at_ack) begin
      inj_valid = 1'b1;
      inj_data  = pdata;
    end
    ready_pre = inst_q.size() < DEPTH;
    if (got && inst && inst_q.size() > 0) inst_q.delete(0);
    if (got && ram && we) begin
      for (int k = 0; k < 16; k++) if (sel[k]) ram_m[line][8*k +: 8] = dat[8*k +: 8];
      if (sel == 16'hFFFF) ram_known[line] = 1'b1;
    end
    if (push_at_ack && ready_pre) inst_q.push_back(pdata);
    @(negedge clk);
    inj_valid = 1'b0;
    check("inj_count", 128'(o_inj_count), 128'(inst_q.size()));
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    check("inj_ready", 128'(o_inj_ready), 128'(inst_q.size() < DEPTH));
    inj_valid = 1'b1;
    inj_data  = d;
    if (inst_q.size() < DEPTH) inst_q.push_back(d);
    @(negedge clk);
    inj_valid = 1'b0;
    check("inj_count", 128'(o_inj_count), 128'(inst_q.size()));
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ack"},   128'(o_wb_ack),    128'd0);
    check({tag, "_err"},   128'(o_wb_err),    128'd0);
    check({tag, "_dat"},   o_wb_dat,          128'd0);
    check({tag, "_ready"}, 128'(o_inj_ready), 128'd1);
    check({tag, "_count"}, 128'(o_inj_count), 128'd0);
  endtask

  // Start a write, then abandon it in WAIT by dropping stb or by reset.
  task automatic abort_txn(input bit use_rst, input logic [31:0] adr, input logic [127:0] dat);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = adr;  wb_sel = 16'hFFFF; wb_wdat = dat;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    if (use_rst) rst = 1'b1;
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b0;
      inst_q.delete();
      reset_check("midrst");
    end
    repeat (WS + 4) @(negedge clk);
  endtask

  // Monitor: every ack/err must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_wb_ack || o_wb_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {o_wb_ack, o_wb_err}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", 128'(o_wb_err), 128'(e.is_err));
          check("resp_ack", 128'(o_wb_ack), 128'(!e.is_err));
          check("latency",  128'(cyc),      128'(e.due));
          if (e.chk) check("rdata", o_wb_dat, e.dat);
          @(negedge clk);
          check("one_cycle_pulse", {o_wb_ack, o_wb_err}, 128'd0);
        end
      end
    end
  end

  initial begin
    int line;
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_sel = '0; wb_wdat = '0; inj_valid = 1'b0; inj_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_check("por");

    // Preload lines 0..7 and the last line; line 1 is all 0x55.
    for (int l = 0; l < 8; l++)
      bus(1'b1, 32'h1000 + 32'(16 * l), 16'hFFFF, (l == 1) ? {16{8'h55}} : rnd128());
    bus(1'b1, 32'h1FF0, 16'hFFFF, rnd128());

    // Injected instruction on lane 0, then an empty-FIFO fetch.
    push(32'hE3A01005);
    bus(1'b0, 32'h0, 16'hFFFF, '0);
    bus(1'b0, 32'h8, 16'hFFFF, '0);

    // Byte-masked write, then readback of the merged line.
    bus(1'b1, 32'h1010, 16'h00FF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    bus(1'b0, 32'h1010, 16'h0000, '0);

    // Error terminations with one FIFO entry held to prove it is untouched.
    push(32'hA5A5_0001);
    bus(1'b0, 32'h8000, 16'hFFFF, '0);
    bus(1'b1, 32'h0004, 16'hFFFF, rnd128());
    bus(1'b1, 32'h2000, 16'hFFFF, rnd128());
    bus(1'b0, 32'h0FF0, 16'hFFFF, '0);
    bus(1'b0, 32'h0100, 16'hFFFF, '0);
    bus(1'b0, 32'h1FFC, 16'hFFFF, '0);
    bus(1'b0, 32'h00FC, 16'hFFFF, '0);

    // Overfill: nine pushes into eight slots, then nine fetches.
    for (int i = 0; i < 9; i++) push(32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 9; i++) bus(1'b0, 32'(i * 20) % 32'h100, 16'hFFFF, '0);

    // Push landing on the ack of an empty-FIFO fetch must not bypass.
    bus(1'b0, 32'h4, 16'hFFFF, '0, 1'b1, 32'hBEEF_0042);
    bus(1'b0, 32'hC, 16'hFFFF, '0);

    // Aborts in WAIT: neither may write or respond.
    abort_txn(1'b0, 32'h1030, rnd128());
    bus(1'b0, 32'h1030, 16'hFFFF, '0);
    push(32'h1234_5678);
    abort_txn(1'b1, 32'h1040, rnd128());
    bus(1'b0, 32'h1040, 16'hFFFF, '0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      line = $urandom_range(0, 8);
      if (line == 8) line = 255;
      case ($urandom_range(0, 5))
        0: repeat ($urandom_range(1, 3)) push($urandom);
        1: bus(1'b0, 32'($urandom_range(0, 255)), 16'($urandom), '0);
        2: bus(1'b0, 32'h1000 + 32'(16 * line) + 32'($urandom_range(0, 15)), 16'($urandom), '0);
        3: bus(1'b1, 32'h1000 + 32'(16 * line), 16'($urandom), rnd128());
        4: begin
          case ($urandom_range(0, 3))
            0: bus($urandom_range(0, 1) == 1, 32'h100 + 32'($urandom_range(0, 32'hEFF)), 16'hFFFF, rnd128());
            1: bus($urandom_range(0, 1) == 1, 32'h2000 + 32'(16 * $urandom_range(0, 1000)), 16'hFFFF, rnd128());
            2: bus(1'b1, 32'($urandom_range(0, 255)), 16'hFFFF, rnd128());
            default: bus(1'b0, 32'hFFFF_FFF0, 16'hFFFF, '0);
          endcase
        end
        default: bus(1'b0, 32'($urandom_range(0, 255)), 16'hFFFF, '0, 1'b1, $urandom);
      endcase
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drain", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
